fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID register.
//  - Owns the PC and drives the instruction-bus request/response handshake.
//  - Buffers the returned instruction and presents {instr, PCF, PCPlus4F} to IF/ID.
//  - Raises fetch_busy so the hazard unit can stall F/D while a fetch is outstanding.
// PARAMETERS
//  RESET_PC  32'hbfc00000  PC value loaded on reset; first fetch address
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  resetn          in   1   reset, synchronous, active-low
//  StallF          in   1   hazard unit: hold PC and buffered instruction
//  redirect_valid  in   1   1-cycle pulse: discard current fetch, restart at redirect_pc
//  redirect_pc     in   32  target PC, sampled when redirect_valid=1
//  ireq            out  33  ibus_req_t {valid, addr[31:0]}
//  iresp           in   34  ibus_resp_t {addr_ok, data_ok, data[31:0]}
//  instr           out  34  ibus_resp_t to IF/ID: addr_ok=0, data_ok=instr valid, data=instruction
//  PCF             out  32  PC of the instruction on instr
//  PCPlus4F        out  32  PCF+4, mod 2^32
//  fetch_busy      out  1   1 while no valid, un-killed instruction is buffered
// BEHAVIOUR
//  - Reset: PCF=RESET_PC, PCPlus4F=RESET_PC+4, state=REQ, ireq.valid=0 during reset cycle,
//    instr='0, fetch_busy=1, kill=0, pend=0. Reset mid-transaction abandons it; no drain.
//  - FSM states:
//    REQ:  ireq.valid=1, ireq.addr=PCF.
//          addr_ok&data_ok  -> DONE, capture data.
//          addr_ok only     -> WAIT.
//          Hold valid/addr stable until addr_ok.
//    WAIT: ireq.valid=0; data_ok -> DONE, capture data.
//    DONE: ireq.valid=0; instr.data_ok=1; fetch_busy=0.
//          ~StallF -> PCF<=PCPlus4F, state=REQ (next-cycle request).
//          StallF  -> hold all outputs.
//  - Latency: single-cycle handshake response gives instr.data_ok on the cycle after the request.
//  - PCPlus4F is combinational from PCF. 0xFFFFFFFC wraps to 0x00000000.
//  - Redirect, highest priority, overrides StallF:
//    DONE, or REQ before addr_ok -> PCF<=redirect_pc, state=REQ, buffered instr dropped.
//      Request not yet accepted, so no drain is needed.
//    REQ with addr_ok same cycle, or WAIT -> transaction accepted, so set kill=1, pend_pc=redirect_pc.
//      Wait for data_ok, discard that data, then PCF<=pend_pc, state=REQ.
//    data_ok in same cycle as redirect -> data discarded; next REQ at redirect_pc.
//    Second redirect while kill=1 -> pend_pc overwritten (latest wins); still exactly one drain.
//  - instr.data_ok never asserts for killed data; fetch_busy=1 throughout a drain.
//  - At most one outstanding ibus transaction at any time.
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN
//    Defined: in REQ with PCF[1:0]!=0, no bus request is issued (ireq.valid=0).
//      State goes to DONE with instr.data='0 (nop).
//      Extra output fetch_adel (1) = 1 alongside instr.data_ok and held while in DONE.
//      Redirect clears fetch_adel.
//    Undefined: no fetch_adel port. Misaligned PCF is issued on the bus unchanged.
// TESTING
//  - Reset release, memory addr_ok&data_ok same cycle returning 0x24080001
//    -> ireq.addr=0xbfc00000; next cycle instr.data_ok=1, data=0x24080001,
//       PCF=0xbfc00000, PCPlus4F=0xbfc00004.
//  - addr_ok delayed 3 cycles, data_ok 2 cycles after addr_ok
//    -> valid/addr stable for 4 cycles; fetch_busy=1 until data arrives; then PCF advances to 0xbfc00004.
//  - StallF=1 for 5 cycles while in DONE
//    -> instr/PCF unchanged; ireq.valid=0; no PC advance until StallF drops.
//  - Redirect to 0x80000180 while in WAIT
//    -> stale data_ok discarded (instr.data_ok stays 0); next ireq.addr=0x80000180.
//  - Two redirects (0x80000000, then 0x80000180) during one drain
//    -> one discarded response; single new request at 0x80000180.
//  - FETCH_ALIGN_CHECK_EN, redirect_pc=0x80000002
//    -> no ireq.valid; fetch_adel=1, instr.data=0, PCF=0x80000002.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-bus bundle between fetch_stage (master) and instruction memory (slave).
// ireq = {valid, addr[31:0]}, iresp = {addr_ok, data_ok, data[31:0]}.
interface fetch_stage_if;
    logic [32:0] ireq;
    logic [33:0] iresp;

    modport master (output ireq, input iresp);
    modport slave  (input ireq, output iresp);
endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, runs the ibus handshake and buffers one instruction for IF/ID.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned PCs are not fetched and raise o_fetch_adel.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic          clk,
    input  logic          resetn,
    fetch_stage_if.master bus,
    input  logic          i_StallF,
    input  logic          i_redirect_valid,
    input  logic [31:0]   i_redirect_pc,
    output logic [33:0]   o_instr,
    output logic [31:0]   o_PCF,
    output logic [31:0]   o_PCPlus4F,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic          o_fetch_adel,
`endif
    output logic          o_fetch_busy
);
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_pend_pc, w_pend_pc_nxt;
    logic [31:0] r_data, w_data_nxt;
    logic        r_kill, w_kill_nxt;
    logic        w_addr_ok, w_data_ok, w_misalign;
    logic [31:0] w_rdata;

    assign w_addr_ok = bus.iresp[33];
    assign w_data_ok = bus.iresp[32];
    assign w_rdata   = bus.iresp[31:0];

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_misalign = (r_pc[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // State, PC, drain and instruction-buffer registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_REQ;
            r_pc      <= RESET_PC;
            r_pend_pc <= 32'h0000_0000;
            r_kill    <= 1'b0;
            r_data    <= 32'h0000_0000;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_pend_pc <= w_pend_pc_nxt;
            r_kill    <= w_kill_nxt;
            r_data    <= w_data_nxt;
        end
    end

    // Next-state logic; a redirect after the bus accepted the request must drain that response
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_pend_pc_nxt = r_pend_pc;
        w_kill_nxt    = r_kill;
        w_data_nxt    = r_data;
        case (r_state)
            S_REQ: begin
                if (w_misalign) begin
                    if (i_redirect_valid) begin
                        w_pc_nxt = i_redirect_pc;
                    end else begin
                        w_state_nxt = S_DONE;
                        w_data_nxt  = 32'h0000_0000;
                    end
                end else if (!w_addr_ok) begin
                    if (i_redirect_valid) begin
                        w_pc_nxt = i_redirect_pc;
                    end else begin
                        w_pc_nxt = r_pc;
                    end
                end else if (w_data_ok) begin
                    if (i_redirect_valid) begin
                        w_pc_nxt = i_redirect_pc;
                    end else begin
                        w_state_nxt = S_DONE;
                        w_data_nxt  = w_rdata;
                    end
                end else begin
                    w_state_nxt = S_WAIT;
                    if (i_redirect_valid) begin
                        w_kill_nxt    = 1'b1;
                        w_pend_pc_nxt = i_redirect_pc;
                    end else begin
                        w_kill_nxt = 1'b0;
                    end
                end
            end
            S_WAIT: begin
                if (w_data_ok) begin
                    w_kill_nxt = 1'b0;
                    if (i_redirect_valid) begin
                        w_state_nxt = S_REQ;
                        w_pc_nxt    = i_redirect_pc;
                    end else if (r_kill) begin
                        w_state_nxt = S_REQ;
                        w_pc_nxt    = r_pend_pc;
                    end else begin
                        w_state_nxt = S_DONE;
                        w_data_nxt  = w_rdata;
                    end
                end else if (i_redirect_valid) begin
                    w_kill_nxt    = 1'b1;
                    w_pend_pc_nxt = i_redirect_pc;
                end else begin
                    w_kill_nxt = r_kill;
                end
            end
            S_DONE: begin
                if (i_redirect_valid) begin
                    w_state_nxt = S_REQ;
                    w_pc_nxt    = i_redirect_pc;
                end else if (!i_StallF) begin
                    w_state_nxt = S_REQ;
                    w_pc_nxt    = r_pc + 32'd4;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
                w_kill_nxt  = 1'b0;
            end
        endcase
    end

    // Bus request and IF/ID outputs; request is suppressed while reset is asserted
    always_comb begin
        bus.ireq     = {(resetn && (r_state == S_REQ) && !w_misalign), r_pc};
        o_instr      = {1'b0, (r_state == S_DONE), r_data};
        o_PCF        = r_pc;
        o_PCPlus4F   = r_pc + 32'd4;
        o_fetch_busy = (r_state != S_DONE);
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_adel;

    // Address-error flag follows the instruction held in DONE
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_adel <= 1'b0;
        end else begin
            r_adel <= (w_state_nxt == S_DONE) && w_misalign;
        end
    end

    assign o_fetch_adel = r_adel;
`endif
endmodule
